// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - Shared types and constants for the fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry queue of fetched {pc, instr} with flush.
// DEPTH is a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [63:0]                  push_pc_i,
  input  logic [31:0]                  push_instr_i,
  input  logic                         pop_i,
  output logic [63:0]                  head_pc_o,
  output logic [31:0]                  head_instr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Payload needs no reset: nothing is read from an entry until it is pushed.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= '{pc: push_pc_i, instr: push_instr_i};
    end
  end

  assign head_pc_o    = mem_q[rd_ptr_q].pc;
  assign head_instr_o = mem_q[rd_ptr_q].instr;
  assign count_o      = count_q;
  assign full_o       = (count_q == CW'(DEPTH));
  assign empty_o      = (count_q == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - Fetch PC owner, in-order imem requests and prefetch queue for IF/ID.
// FETCH_BYPASS_EN: a kept response into an empty queue is presented in its arrival cycle.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e  state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [63:0]   head_pc;
  logic [31:0]   head_instr;
  logic [CW:0]   credit_used;
  logic          req_hs, rsp_keep, push, pop;

  // Credits cover both in-flight words (stale ones too) and buffered words.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = (state_q != ST_BOOT) && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && rsp_keep;
  assign out_valid = !fifo_empty || bypass;
  assign out_pc    = !fifo_empty ? head_pc    : (bypass ? rsp_pc_q      : 64'h0);
  assign out_instr = !fifo_empty ? head_instr : (bypass ? imem_rsp_data : NOP_INSTR);
  assign push      = rsp_keep && !(bypass && out_ready);
`else
  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_empty ? 64'h0     : head_pc;
  assign out_instr = fifo_empty ? NOP_INSTR : head_instr;
  assign push      = rsp_keep;
`endif

  assign pop = out_valid && out_ready && !fifo_empty;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);
    if (req_hs)   fetch_pc_d = fetch_pc_q + 64'd4;
    if (rsp_keep) rsp_pc_d   = rsp_pc_q + 64'd4;
    if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      drop_cnt_d = outstanding_d;
    end
    if (state_q == ST_BOOT)     state_d = ST_FETCH;
    else if (drop_cnt_d != '0)  state_d = ST_FLUSH;
    else                        state_d = ST_FETCH;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk),
    .rst_ni       (reset),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_pc_i    (rsp_pc_q),
    .push_instr_i (imem_rsp_data),
    .pop_i        (pop),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr),
    .count_o      (fifo_count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  a_no_push_on_full: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - Randomized bench for fetch_prefetch_queue against a queue-level model.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  pend_t       pend[$];
  ent_t        mq[$];
  logic [63:0] acc_log[$];
  logic [63:0] out_log[$];
  logic [63:0] exp_req;
  bit          boot;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          lat_min = 1, lat_max = 1;
  int          rdy_pct = 100, ordy_pct = 100, redir_pm = 0;
  bit          redir_collide = 0, redir_next = 0;
  logic [63:0] redir_tgt = 64'h100;
  int          collide_hits = 0;
  int          redir_out_idx = -1;
  int          first_out_s = -1;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    logic [63:0] h;
    h = a * 64'h9E3779B97F4A7C15;
    return h[50:19] ^ a[31:0];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [63:0] log_at(ref logic [63:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // Entered at a falling edge; compares, drives, models the rising edge, returns at the next falling edge.
  task automatic cycle();
    bit          exp_rv, req_hs, rsp_fire, out_hs, redir;
    logic [63:0] tgt;
    pend_t       p;
    exp_rv = !boot && (pend.size() + mq.size() < DEPTH);
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, exp_req);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_instr", out_instr, mq[0].instr);
    end
    if (out_valid && first_out_s < 0) first_out_s = cyc - rel_cyc;

    imem_req_ready = ($urandom_range(99) < rdy_pct);
    rsp_fire       = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp_fire;
    imem_rsp_data  = rsp_fire ? mem_word(pend[0].addr) : $urandom;
    out_ready      = ($urandom_range(99) < ordy_pct);
    req_hs         = exp_rv && imem_req_ready;
    out_hs         = (mq.size() > 0) && out_ready;
    if (redir_collide)   redir = rsp_fire && req_hs;
    else if (redir_next) redir = 1'b1;
    else                 redir = ($urandom_range(999) < redir_pm);
    if (redir_collide || redir_next) tgt = redir_tgt;
    else begin
      case ($urandom_range(2))
        0:       tgt = 64'h100 + 64'(4 * $urandom_range(63));
        1:       tgt = 64'hFFFF_FFFF_FFFF_FFF4;
        default: tgt = {$urandom, $urandom} & ~64'h3;
      endcase
    end
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : ({$urandom, $urandom} & ~64'h3);

    @(posedge clk);
    if (out_hs) begin
      out_log.push_back(mq[0].pc);
      void'(mq.pop_front());
    end
    if (rsp_fire) begin
      p = pend.pop_front();
      if (!p.stale && !redir) mq.push_back('{p.addr, mem_word(p.addr)});
    end
    if (req_hs) begin
      acc_log.push_back(exp_req);
      pend.push_back('{exp_req, cyc + lat_min + $urandom_range(lat_max - lat_min), 1'b0});
      exp_req += 64'd4;
    end
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      mq.delete();
      exp_req       = tgt;
      redir_out_idx = out_log.size();
      if (redir_collide) collide_hits++;
      redir_collide = 1'b0;
      redir_next    = 1'b0;
    end
    boot = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_instr", out_instr, 32'h00000013);
    pend.delete();
    mq.delete();
    acc_log.delete();
    out_log.delete();
    boot        = 1'b1;
    exp_req     = RESET_PC;
    first_out_s = -1;
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    rel_cyc = cyc;
  endtask

  initial begin
    int viol;
    #2;
    // Streaming with a 1-cycle always-ready memory.
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; ordy_pct = 100; redir_pm = 0;
    run(30);
    chk("first_out_cycle", first_out_s, 3);
    chk("req0", log_at(acc_log, 0), 64'h0);
    chk("req1", log_at(acc_log, 1), 64'h4);
    chk("req2", log_at(acc_log, 2), 64'h8);
    chk("stream_count", out_log.size(), 27);
    chk("stream_last", log_at(out_log, 26), 64'h68);

    // Back-pressure: exactly DEPTH requests, then resume at 0x10.
    do_reset();
    ordy_pct = 0;
    run(20);
    chk("bp_req_count", acc_log.size(), 4);
    chk("bp_req_last", log_at(acc_log, 3), 64'hC);
    chk("bp_req_valid", imem_req_valid, 1'b0);
    acc_log.delete();
    ordy_pct = 100;
    run(10);
    chk("bp_resume", log_at(acc_log, 0), 64'h10);

    // Reset with the queue full, then refetch from RESET_PC.
    do_reset();
    ordy_pct = 0;
    run(20);
    chk("full_out_valid", out_valid, 1'b1);
    do_reset();
    ordy_pct = 100;
    run(10);
    chk("rr_out0", log_at(out_log, 0), RESET_PC);
    chk("rr_out1", log_at(out_log, 1), RESET_PC + 64'd4);

    // Redirect with two requests in flight.
    do_reset();
    lat_min = 2; lat_max = 2;
    run(5);
    rdy_pct = 0; redir_tgt = 64'h100; redir_next = 1'b1;
    run(1);
    chk("redir_pend_stale", pend.size(), 1);
    chk("redir_out_valid_next", out_valid, 1'b0);
    rdy_pct = 100;
    run(15);
    chk("redir_hs_kept", log_at(out_log, 1), 64'h4);
    chk("redir_first", log_at(out_log, redir_out_idx), 64'h100);
    viol = 0;
    foreach (out_log[i]) if (out_log[i] == 64'h8 || out_log[i] == 64'hC) viol++;
    chk("redir_no_stale", viol, 0);

    // Redirect coinciding with a response and a request handshake.
    do_reset();
    lat_min = 1; lat_max = 1;
    run(6);
    redir_collide = 1'b1; redir_tgt = 64'h100; collide_hits = 0;
    for (int i = 0; i < 10 && collide_hits == 0; i++) cycle();
    chk("collide_hit", collide_hits, 1);
    run(10);
    chk("collide_out0", log_at(out_log, redir_out_idx), 64'h100);
    chk("collide_out1", log_at(out_log, redir_out_idx + 1), 64'h104);

    // Random ready and latency: 1000 strictly sequential instructions.
    do_reset();
    lat_min = 1; lat_max = 3; rdy_pct = 60; ordy_pct = 70;
    for (int i = 0; i < 20000 && out_log.size() < 1000; i++) cycle();
    chk("rand_done", out_log.size() >= 1000, 1'b1);
    viol = 0;
    for (int i = 1; i < out_log.size(); i++) if (out_log[i] != out_log[i-1] + 64'd4) viol++;
    chk("rand_seq_plus4", viol, 0);
    chk("rand_start", log_at(out_log, 0), RESET_PC);

    // Random redirects, including targets that wrap past 2^64.
    redir_pm = 20;
    run(600);
    redir_pm = 0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register. Owns the fetch PC, issues in-order word requests to instruction memory over a valid/ready handshake, buffers returned words with their PCs in a small queue, and presents them to IF/ID with valid/ready. Applies branch redirects from the MEM-stage branch control by flushing the queue and discarding stale in-flight responses.

## Interface
- DEPTH, 4, queue entries and maximum in-flight plus buffered words (power of two, ≥2)
- RESET_PC, 64'h0, first fetch address after reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- redirect_valid  in  1  taken branch / PC redirect this cycle
- redirect_pc  in  64  redirect target (word aligned)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  fetch address
- imem_rsp_valid  in  1  response word valid (in order, ≥1 cycle after its request)
- imem_rsp_data  in  32  instruction word
- out_valid  out  1  instruction available to IF/ID
- out_ready  in  1  IF/ID accepts
- out_pc  out  64  PC of presented instruction
- out_instr  out  32  presented instruction

## Operation
- FSM: BOOT → FETCH ↔ FLUSH. BOOT lasts exactly one cycle after reset release, no request. FETCH: normal. FLUSH: drop_cnt > 0; new requests to the redirected PC still allowed.
- Registers: fetch_pc, rsp_pc (PC of next expected kept response), outstanding (all in-flight, incl. to-be-dropped), drop_cnt, queue count. Counters are $clog2(DEPTH+1) bits.
- Issue rule: imem_req_valid = (state≠BOOT) && (outstanding + count < DEPTH). On handshake: fetch_pc += 4, outstanding += 1.
- Response: outstanding −= 1. If drop_cnt > 0: drop_cnt −= 1, word discarded. Else {rsp_pc, data} enqueued, rsp_pc += 4.
- Output: head entry; dequeue on out_valid && out_ready.
- Redirect (highest priority): queue flushed; fetch_pc and rsp_pc ← redirect_pc; drop_cnt ← outstanding after this cycle's issue/response updates (request accepted same cycle counts as stale; response arriving same cycle is discarded). Output handshake in the redirect cycle still completes; out_valid is 0 next cycle.
- Reset mid-operation: all state cleared immediately; any later responses for pre-reset requests are the memory's responsibility (memory is reset too).
- PC arithmetic 64-bit, wraps modulo 2^64 without flag.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, out_valid 0, out_pc 0, out_instr 32'h00000013, state BOOT, all counters 0.
- imem_req_addr = fetch_pc (registered). First request visible the cycle after BOOT.
- Response at cycle N into empty queue → out_valid at N+1 (macro off).
- Full: outstanding + count = DEPTH → imem_req_valid 0 same cycle; a dequeue frees credit for issue in the following cycle.
- Simultaneous enqueue and dequeue with count = DEPTH−... never overflows by credit rule; enqueue on full is an assertion failure.
- Back-to-back ready memory with 1-cycle latency and out_ready=1 sustains one instruction per cycle.

## Configuration
- FETCH_BYPASS_EN defined: response into an empty queue (and not dropped) is presented combinationally the same cycle (out_valid at N); if out_ready that cycle it is not written to the queue. out_pc/out_instr become partly combinational.
- Undefined: outputs purely registered from the queue; one extra cycle latency.

## Structure
- Package fetch_pkg: NOP_INSTR = 32'h00000013, typedef fetch_entry_t {pc[63:0], instr[31:0]}, FSM state enum.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push/pop/flush, count, full/empty; wraparound pointers.

## Test plan
- Reset release, memory always ready, 1-cycle latency, out_ready=1 → requests 0x0,0x4,0x8…; out_pc 0x0 at cycle 3 after release, then one per cycle.
- out_ready=0 held → exactly DEPTH=4 requests issued (0x0–0xC), then imem_req_valid 0; release out_ready → fetching resumes at 0x10.
- Redirect to 0x100 with 2 requests in flight → both responses dropped, next out_pc 0x100, no 0x8/0xC output.
- Redirect same cycle as response and request handshake → both stale words dropped; drop_cnt correct; subsequent out_pc 0x100, 0x104.
- Memory ready toggling randomly with 1–3 cycle latency, 1000 instructions → out_pc strictly +4 sequence, data matches memory model.
- Assert reset mid-stream with queue full → next cycle out_valid 0, imem_req_valid 0; after release refetch from RESET_PC.
